// File: rtl/wrr_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter family.
// The optional burst lock is enabled by defining WRR_LOCK_EN.
package wrr_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } wrr_state_e;

    localparam int unsigned DEFAULT_REQUESTERS = 32'd4;
    localparam int unsigned DEFAULT_WEIGHT_W   = 32'd4;

    // Index increment that wraps back to zero at the modulus.
    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned modulus);
        return ((idx + 32'd1) >= modulus) ? 32'd0 : (idx + 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotated first-one finder: the first set request bit at or
// after the pointer, wrapping modulo REQUESTERS.
module rr_pick
    import wrr_pkg::*;
#(
    parameter int unsigned REQUESTERS = DEFAULT_REQUESTERS,
    localparam int unsigned IDX_W     = $clog2(REQUESTERS)
) (
    input  logic [REQUESTERS-1:0] request,
    input  logic [IDX_W-1:0]      pointer,
    output logic                  found,
    output logic [IDX_W-1:0]      index
);

    int unsigned pos_s;

    // Scan offsets from farthest to nearest so the nearest match wins.
    always_comb begin
        found = 1'b0;
        index = '0;
        pos_s = 32'd0;
        for (int i = int'(REQUESTERS) - 1; i >= 0; i--) begin
            pos_s = (32'(pointer) + 32'(i)) % REQUESTERS;
            if (request[pos_s]) begin
                found = 1'b1;
                index = IDX_W'(pos_s);
            end else begin
                found = found;
            end
        end
    end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// N-way weighted round-robin arbiter with burst tenancy of up to weight[i] cycles.
// Define WRR_LOCK_EN to add the per-requester lock input that pins the current owner.
module weighted_rr_arbiter
    import wrr_pkg::*;
#(
    parameter int unsigned REQUESTERS = DEFAULT_REQUESTERS,
    parameter int unsigned WEIGHT_W   = DEFAULT_WEIGHT_W,
    localparam int unsigned IDX_W     = $clog2(REQUESTERS)
) (
    input  logic                           clk,
    input  logic                           reset,
`ifdef WRR_LOCK_EN
    input  logic [REQUESTERS-1:0]          lock,
`endif
    input  logic [REQUESTERS-1:0]          request,
    input  logic [REQUESTERS*WEIGHT_W-1:0] weight,
    output logic [REQUESTERS-1:0]          grant,
    output logic                           grant_valid,
    output logic [IDX_W-1:0]               grant_index,
    output logic [WEIGHT_W-1:0]            credit
);

    wrr_state_e              state_r,       state_n_s;
    logic [IDX_W-1:0]        pointer_r,     pointer_n_s;
    logic [REQUESTERS-1:0]   grant_r,       grant_n_s;
    logic                    grant_valid_r, grant_valid_n_s;
    logic [IDX_W-1:0]        grant_index_r, grant_index_n_s;
    logic [WEIGHT_W-1:0]     credit_r,      credit_n_s;

    logic                    pick_found_s;
    logic [IDX_W-1:0]        pick_index_s;
    logic [WEIGHT_W-1:0]     pick_weight_raw_s;
    logic [WEIGHT_W-1:0]     pick_weight_s;
    logic                    owner_req_s;
    logic                    lock_hold_s;

    rr_pick #(
        .REQUESTERS (REQUESTERS)
    ) u_pick (
        .request (request),
        .pointer (pointer_r),
        .found   (pick_found_s),
        .index   (pick_index_s)
    );

    // A zero weight still buys one cycle of tenancy.
    assign pick_weight_raw_s = weight[32'(pick_index_s)*WEIGHT_W +: WEIGHT_W];
    assign pick_weight_s     = (pick_weight_raw_s == '0) ? WEIGHT_W'(1) : pick_weight_raw_s;
    assign owner_req_s       = request[grant_index_r];

`ifdef WRR_LOCK_EN
    assign lock_hold_s = lock[grant_index_r] & owner_req_s;
`else
    assign lock_hold_s = 1'b0;
`endif

    // Next-state: hold the burst, hand over without a bubble, or fall idle.
    always_comb begin
        state_n_s       = state_r;
        pointer_n_s     = pointer_r;
        grant_n_s       = grant_r;
        grant_valid_n_s = grant_valid_r;
        grant_index_n_s = grant_index_r;
        credit_n_s      = credit_r;
        case (state_r)
            IDLE: begin
                if (pick_found_s) begin
                    state_n_s                 = GRANT;
                    grant_n_s                 = '0;
                    grant_n_s[pick_index_s]   = 1'b1;
                    grant_valid_n_s           = 1'b1;
                    grant_index_n_s           = pick_index_s;
                    credit_n_s                = pick_weight_s;
                    pointer_n_s               = IDX_W'(wrap_inc(32'(pick_index_s), REQUESTERS));
                end else begin
                    state_n_s = IDLE;
                end
            end
            GRANT: begin
                if (lock_hold_s) begin
                    credit_n_s = credit_r;
                end else if (owner_req_s && (credit_r > WEIGHT_W'(1))) begin
                    credit_n_s = credit_r - WEIGHT_W'(1);
                end else if (pick_found_s) begin
                    grant_n_s               = '0;
                    grant_n_s[pick_index_s] = 1'b1;
                    grant_valid_n_s         = 1'b1;
                    grant_index_n_s         = pick_index_s;
                    credit_n_s              = pick_weight_s;
                    pointer_n_s             = IDX_W'(wrap_inc(32'(pick_index_s), REQUESTERS));
                end else begin
                    state_n_s       = IDLE;
                    grant_n_s       = '0;
                    grant_valid_n_s = 1'b0;
                    credit_n_s      = '0;
                end
            end
            default: begin
                state_n_s       = IDLE;
                grant_n_s       = '0;
                grant_valid_n_s = 1'b0;
                credit_n_s      = '0;
            end
        endcase
    end

    // State and registered outputs, cleared asynchronously by reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r       <= IDLE;
            pointer_r     <= '0;
            grant_r       <= '0;
            grant_valid_r <= 1'b0;
            grant_index_r <= '0;
            credit_r      <= '0;
        end else begin
            state_r       <= state_n_s;
            pointer_r     <= pointer_n_s;
            grant_r       <= grant_n_s;
            grant_valid_r <= grant_valid_n_s;
            grant_index_r <= grant_index_n_s;
            credit_r      <= credit_n_s;
        end
    end

    assign grant       = grant_r;
    assign grant_valid = grant_valid_r;
    assign grant_index = grant_index_r;
    assign credit      = credit_r;

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
N-way weighted round-robin arbiter with burst tenancy. A granted requester keeps the grant for up to `weight[i]` consecutive cycles while it keeps requesting. Ownership then rotates to the next requester after the current owner. Sits in front of shared buses and memory ports where some masters need proportionally more bandwidth than plain one-cycle round-robin gives.

Parameters:
- REQUESTERS, 4, number of requesters; must be ≥2.
- WEIGHT_W, 4, width of each per-requester weight field.
- IDX_W, $clog2(REQUESTERS), width of an index (derived localparam).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- request  in  REQUESTERS  request vector, level-sensitive
- weight  in  REQUESTERS*WEIGHT_W  packed burst weights; requester i uses bits [i*WEIGHT_W +: WEIGHT_W]
- grant  out  REQUESTERS  one-hot grant, registered
- grant_valid  out  1  OR of grant, registered
- grant_index  out  IDX_W  index of the current owner, registered; holds its last value when grant_valid=0
- credit  out  WEIGHT_W  cycles of tenancy remaining including the current one, registered

Behaviour:
- Reset values: grant=0, grant_valid=0, grant_index=0, credit=0, pointer=0, state=IDLE.
- Pointer: highest-priority index for the next arbitration. After requester k is granted, pointer=(k+1) mod REQUESTERS.
- Pick function: first set bit of request scanning from pointer upward, wrapping modulo REQUESTERS. It is combinational; no grant is issued when request is zero.
- Effective weight: w_eff = (weight[i]==0) ? 1 : weight[i]. Weight is sampled only at the edge that issues the grant.
- IDLE state:
  - On the edge where request≠0: grant picked index p, state=GRANT, credit=w_eff[p], pointer=p+1 mod N.
  - Latency is one cycle from request to grant.
- GRANT state, owner o, evaluated at each edge:
  - request[o]=1 and credit>1: hold the grant, credit-1.
  - Otherwise (request[o] dropped, or credit==1): re-arbitrate at the same edge using the updated pointer (o+1).
    - If some request is set: new owner p, fresh credit, no idle bubble.
    - If none: state=IDLE and all grant outputs go low (grant_index holds).
- Sole requester: if o is the only requester when its credit expires, it is re-granted immediately with fresh credit (wrap-around to itself).
- A request dropped mid-burst forfeits the remaining credit.
- A new request arriving mid-burst waits; it is never preemptive.
- Weight changes during a burst do not affect the current credit.
- Fairness bound: a continuously requesting master waits at most sum of w_eff of the other requesters.
- Reset asserted mid-burst clears everything immediately (async); the first arbitration after release starts from pointer 0.
- grant is always one-hot or zero; grant_valid==|grant.

Optional Feature:
- Macro: WRR_LOCK_EN.
- Enabled:
  - Adds input `lock` (REQUESTERS bits).
  - While lock[o]=1 and request[o]=1, the owner keeps the grant regardless of credit; credit freezes at its current value and does not decrement below 1.
  - When lock drops, normal decrement resumes.
  - Lock on a non-owner has no effect.
- Disabled: no `lock` port; behaviour exactly as above.

Decomposition:
- Package wrr_pkg holds:
  - state enum typedef {IDLE, GRANT}
  - helper function for modular increment of an index
  - default REQUESTERS and WEIGHT_W constants
- Sub-module rr_pick: combinational rotated first-one finder.
  - Inputs: request, pointer.
  - Outputs: found, index.
  - Reused by future arbiters.

Test Plan:
- Reset, then request=4'b0000 for 5 cycles -> grant=0, grant_valid=0, credit=0 throughout.
- request=4'b1111, all weights=1 -> grant rotates 0001,0010,0100,1000,0001 on consecutive cycles, first grant one cycle after request.
- weights={1,1,1,3} (req0=3), request=4'b0011 steady -> grant pattern 0,0,0,1,0,0,0,1; credit shows 3,2,1,1,3,…
- Owner 0 with weight=4 drops request after 2 granted cycles while req2 is high -> grant moves to 2 on the next edge with credit=weight[2], no bubble cycle.
- Only req1 high, weight=2 -> continuous grant=0010, credit 2,1,2,1…; assert reset mid-burst -> all outputs 0 asynchronously; after release with req3 only -> grant=1000.
- WRR_LOCK_EN: owner 0 with weight=2 and lock[0]=1 for 6 cycles, req1 high -> grant stays 0001 and credit holds 1; lock drops -> grant moves to 0010 next edge.
